// File: rtl/pio_host_pkg.sv
// Shared types and constants for the PIO expansion-port bus initiator.
package pio_host_pkg;

  localparam int ADDR_W = 23;
  localparam int PH_W   = 4;

  localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};
  localparam logic [PH_W-1:0] PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } pio_state_e;

  // Phase counter load value: a phase of cyc cycles counts cyc-1 down to 0.
  function automatic logic [PH_W-1:0] phase_load(input int cyc);
    return PH_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/pio_phase_timer.sv
// Loadable down-counter that times one bus phase; tc flags the last cycle.
module pio_phase_timer
  import pio_host_pkg::*;
(
  input  logic            CLK,
  input  logic            nRESET,
  input  logic            load,
  input  logic [PH_W-1:0] load_val,
  output logic            tc
);

  logic [PH_W-1:0] count_r;

  // Load on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      count_r <= PH_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != PH_ZERO) begin
      count_r <= count_r - PH_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == PH_ZERO);

endmodule

// File: rtl/pio_host.sv
// PSX-style parallel I/O port initiator: turns single-byte read/write
// commands into timed CS / address / strobe / data bus cycles.
module pio_host
  import pio_host_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_cs2,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [ADDR_W-1:0] A,
  output logic              nCS0,
  output logic              nCS2,
  output logic              nRD,
  output logic              nWR,
  inout  wire  [7:0]        PD
);

  generate
    if ((SETUP_CYC < 1) || (SETUP_CYC > 15) ||
        (STROBE_CYC < 1) || (STROBE_CYC > 15) ||
        (HOLD_CYC < 1) || (HOLD_CYC > 15)) begin : g_bad_param
      $error("pio_host: SETUP_CYC, STROBE_CYC and HOLD_CYC must lie in 1..15");
    end
  endgenerate

  localparam logic [PH_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [PH_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
  localparam logic [PH_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

  pio_state_e        state_r, next_state_s;
  logic              accept_s;
  logic              tc_s, load_s;
  logic [PH_W-1:0]   load_val_s;

  logic              lat_write_r, lat_cs2_r;
  logic [ADDR_W-1:0] lat_addr_r;
  logic [7:0]        lat_wdata_r;

  logic              cur_write_s, cur_cs2_s, in_bus_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [7:0]        cur_wdata_s;

  logic [ADDR_W-1:0] a_r, a_s;
  logic              ncs0_r, ncs0_s, ncs2_r, ncs2_s;
  logic              nrd_r, nrd_s, nwr_r, nwr_s;
  logic              pd_oe_r, pd_oe_s;
  logic [7:0]        pd_out_r, pd_out_s;
  logic              cmd_ready_r, cmd_ready_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [7:0]        rsp_rdata_r, rsp_rdata_s;

  // TURN doubles as an accept slot, so back-to-back commands are spaced
  // SETUP+STROBE+HOLD+1 cycles with exactly one CS-high cycle between them.
  assign accept_s = cmd_valid && ((state_r == IDLE) || (state_r == TURN));

  pio_phase_timer u_timer (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .load     (load_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  // State register.
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: timed phases advance when the phase counter hits zero.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (cmd_valid) next_state_s = SETUP;  else next_state_s = IDLE;
      SETUP:   if (tc_s)      next_state_s = STROBE; else next_state_s = SETUP;
      STROBE:  if (tc_s)      next_state_s = HOLD;   else next_state_s = STROBE;
      HOLD:    if (tc_s)      next_state_s = TURN;   else next_state_s = HOLD;
      TURN:    if (cmd_valid) next_state_s = SETUP;  else next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Phase counter reload on every state change, with that phase's length.
  always_comb begin
    load_s = (next_state_s != state_r);
    case (next_state_s)
      SETUP:   load_val_s = SETUP_LD;
      STROBE:  load_val_s = STROBE_LD;
      HOLD:    load_val_s = HOLD_LD;
      default: load_val_s = PH_ZERO;
    endcase
  end

  // Command latch, loaded only on an accepted command.
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      lat_write_r <= 1'b0;
      lat_cs2_r   <= 1'b0;
      lat_addr_r  <= {ADDR_W{1'b0}};
      lat_wdata_r <= 8'h00;
    end else if (accept_s) begin
      lat_write_r <= cmd_write;
      lat_cs2_r   <= cmd_cs2;
      lat_addr_r  <= cmd_addr;
      lat_wdata_r <= cmd_wdata;
    end else begin
      lat_write_r <= lat_write_r;
      lat_cs2_r   <= lat_cs2_r;
      lat_addr_r  <= lat_addr_r;
      lat_wdata_r <= lat_wdata_r;
    end
  end

  // Output decode: next values of every bus output, derived from the next state.
  always_comb begin
    cur_write_s = accept_s ? cmd_write : lat_write_r;
    cur_cs2_s   = accept_s ? cmd_cs2   : lat_cs2_r;
    cur_addr_s  = accept_s ? cmd_addr  : lat_addr_r;
    cur_wdata_s = accept_s ? cmd_wdata : lat_wdata_r;
    in_bus_s    = (next_state_s == SETUP) || (next_state_s == STROBE) ||
                  (next_state_s == HOLD);

    if (in_bus_s) begin
      a_s      = cur_addr_s;
      pd_out_s = cur_wdata_s;
    end else begin
      a_s      = a_r;
      pd_out_s = pd_out_r;
    end

    ncs0_s      = !(in_bus_s && !cur_cs2_s);
    ncs2_s      = !(in_bus_s && cur_cs2_s);
    nrd_s       = !((next_state_s == STROBE) && !cur_write_s);
    nwr_s       = !((next_state_s == STROBE) && cur_write_s);
    pd_oe_s     = in_bus_s && cur_write_s;
    cmd_ready_s = (next_state_s == IDLE) || (next_state_s == TURN);
    rsp_valid_s = (next_state_s == TURN);

    // Read data is sampled on the edge that ends the final strobe cycle.
    if ((state_r == STROBE) && tc_s) begin
      rsp_rdata_s = lat_write_r ? 8'h00 : PD;
    end else begin
      rsp_rdata_s = rsp_rdata_r;
    end
  end

  // Output registers; reset drops strobes and selects and releases PD at once.
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      a_r         <= {ADDR_W{1'b0}};
      ncs0_r      <= 1'b1;
      ncs2_r      <= 1'b1;
      nrd_r       <= 1'b1;
      nwr_r       <= 1'b1;
      pd_oe_r     <= 1'b0;
      pd_out_r    <= 8'h00;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
    end else begin
      a_r         <= a_s;
      ncs0_r      <= ncs0_s;
      ncs2_r      <= ncs2_s;
      nrd_r       <= nrd_s;
      nwr_r       <= nwr_s;
      pd_oe_r     <= pd_oe_s;
      pd_out_r    <= pd_out_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
    end
  end

  assign A         = a_r;
  assign nCS0      = ncs0_r;
  assign nCS2      = ncs2_r;
  assign nRD       = nrd_r;
  assign nWR       = nwr_r;
  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign PD        = pd_oe_r ? pd_out_r : 8'hzz;

endmodule

// File: tb/tb_pio_host.sv
// Self-checking bench for pio_host: table-driven bus cycles, back-to-back
// traffic, reset mid-strobe, busy-command rejection and a parameter sweep.
module tb_pio_host;
  import pio_host_pkg::*;

  localparam int S0 = 2, ST0 = 3, H0 = 1;
  localparam int LEN0 = S0 + ST0 + H0 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;
  int   checks = 0;
  int   errors = 0;

  // Default-parameter instance signals.
  logic cmd_valid, cmd_write, cmd_cs2, cmd_ready, rsp_valid;
  logic [22:0] cmd_addr, a;
  logic [7:0]  cmd_wdata, rsp_rdata, tb_pd;
  logic ncs0, ncs2, nrd, nwr;
  wire  [7:0]  pd;
  assign pd = (!nrd) ? tb_pd : 8'hzz;

  // Sweep instance signals.
  logic cmd_valid1, cmd_write1, cmd_cs21, cmd_ready1, rsp_valid1;
  logic [22:0] cmd_addr1, a1;
  logic [7:0]  cmd_wdata1, rsp_rdata1, tb_pd1;
  logic ncs01, ncs21, nrd1, nwr1;
  wire  [7:0]  pd1;
  assign pd1 = (!nrd1) ? tb_pd1 : 8'hzz;

  pio_host dut0 (
    .CLK(clk), .nRESET(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_cs2(cmd_cs2), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .A(a), .nCS0(ncs0), .nCS2(ncs2), .nRD(nrd), .nWR(nwr), .PD(pd)
  );

  pio_host #(.SETUP_CYC(1), .STROBE_CYC(15), .HOLD_CYC(1)) dut1 (
    .CLK(clk), .nRESET(nreset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_write(cmd_write1), .cmd_cs2(cmd_cs21), .cmd_addr(cmd_addr1),
    .cmd_wdata(cmd_wdata1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .A(a1), .nCS0(ncs01), .nCS2(ncs21), .nRD(nrd1), .nWR(nwr1), .PD(pd1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboards of expected read data, popped on each response pulse.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  longint     acc_times[$];

  // Response scoreboards and bus-protocol invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!nreset) begin
      if (rsp_valid) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
        else chk("rsp0_rdata", {24'd0, rsp_rdata}, {24'd0, q0.pop_front()});
      end
      if (rsp_valid1) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else chk("rsp1_rdata", {24'd0, rsp_rdata1}, {24'd0, q1.pop_front()});
      end
      chk("strobe_overlap0", {31'd0, (!nrd && !nwr)}, 32'd0);
      chk("cs_overlap0", {31'd0, (!ncs0 && !ncs2)}, 32'd0);
      chk("strobe_overlap1", {31'd0, (!nrd1 && !nwr1)}, 32'd0);
    end
  end

  // Accept-edge recorder for spacing checks.
  always @(posedge clk) begin
    if (!nreset && cmd_valid && cmd_ready) acc_times.push_back($time);
  end

  typedef struct {
    logic        wr;
    logic        cs2;
    logic [22:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  pdv;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic present(input vec_t v);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_cs2 = v.cs2;
    cmd_addr = v.addr; cmd_wdata = v.wdata; tb_pd = v.pdv;
  endtask

  // One full bus cycle on dut0, checked cycle by cycle; called at a falling edge.
  task automatic run_vec(input int idx, input vec_t v);
    logic [5:0] exp_v;
    logic cs_low, str_low;
    chk($sformatf("v%0d_ready", idx), {31'd0, cmd_ready}, 32'd1);
    present(v);
    q0.push_back(v.exp_rd);
    @(posedge clk);
    for (int c = 1; c <= LEN0; c++) begin
      @(negedge clk);
      cs_low  = (c <= S0 + ST0 + H0);
      str_low = (c > S0) && (c <= S0 + ST0);
      exp_v = {!(cs_low && !v.cs2), !(cs_low && v.cs2), !(str_low && !v.wr),
               !(str_low && v.wr), (c == LEN0), (c == LEN0)};
      chk($sformatf("v%0d_ctl_c%0d", idx, c),
          {26'd0, ncs0, ncs2, nrd, nwr, rsp_valid, cmd_ready}, {26'd0, exp_v});
      chk($sformatf("v%0d_addr_c%0d", idx, c), {9'd0, a}, {9'd0, v.addr});
      if (v.wr) begin
        if (c < LEN0) chk($sformatf("v%0d_pd_c%0d", idx, c), {24'd0, pd}, {24'd0, v.wdata});
        else chk($sformatf("v%0d_pd_release", idx), {31'd0, dut0.pd_oe_r}, 32'd0);
      end
      cmd_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int cs_high, str_cnt, cs_cnt;
    vec_t b2b[4];
    vec_t busy_v;

    vecs[0] = '{wr: 1'b0, cs2: 1'b0, addr: 23'h600006, wdata: 8'h00, pdv: 8'hA5, exp_rd: 8'hA5};
    vecs[1] = '{wr: 1'b1, cs2: 1'b1, addr: 23'h000100, wdata: 8'h3C, pdv: 8'h00, exp_rd: 8'h00};
    vecs[2] = '{wr: 1'b0, cs2: 1'b1, addr: 23'h7FFFFF, wdata: 8'h00, pdv: 8'h5A, exp_rd: 8'h5A};
    vecs[3] = '{wr: 1'b1, cs2: 1'b0, addr: 23'h000000, wdata: 8'hFF, pdv: 8'h00, exp_rd: 8'h00};
    vecs[4] = '{wr: 1'b0, cs2: 1'b0, addr: 23'h123456, wdata: 8'h00, pdv: 8'h00, exp_rd: 8'h00};

    b2b[0] = '{wr: 1'b0, cs2: 1'b0, addr: 23'h000010, wdata: 8'h00, pdv: 8'h81, exp_rd: 8'h81};
    b2b[1] = '{wr: 1'b1, cs2: 1'b1, addr: 23'h000020, wdata: 8'h42, pdv: 8'h00, exp_rd: 8'h00};
    b2b[2] = '{wr: 1'b0, cs2: 1'b1, addr: 23'h000030, wdata: 8'h00, pdv: 8'h7E, exp_rd: 8'h7E};
    b2b[3] = '{wr: 1'b1, cs2: 1'b0, addr: 23'h000040, wdata: 8'h99, pdv: 8'h00, exp_rd: 8'h00};

    busy_v = '{wr: 1'b0, cs2: 1'b0, addr: 23'h000777, wdata: 8'h00, pdv: 8'h3D, exp_rd: 8'h3D};

    nreset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_cs2 = 1'b0; cmd_addr = '0; cmd_wdata = '0; tb_pd = '0;
    cmd_valid1 = 1'b0; cmd_write1 = 1'b0; cmd_cs21 = 1'b0; cmd_addr1 = '0; cmd_wdata1 = '0; tb_pd1 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ctl", {26'd0, ncs0, ncs2, nrd, nwr, rsp_valid, cmd_ready}, 32'b111101);
    chk("rst_addr", {9'd0, a}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_pd_oe", {31'd0, dut0.pd_oe_r}, 32'd0);
    chk("rst_ctl1", {26'd0, ncs01, ncs21, nrd1, nwr1, rsp_valid1, cmd_ready1}, 32'b111101);
    nreset = 1'b0;
    @(negedge clk);
    chk("post_rst_ctl", {26'd0, ncs0, ncs2, nrd, nwr, rsp_valid, cmd_ready}, 32'b111101);

    // Table-driven single transfers.
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Back-to-back traffic with cmd_valid held high.
    acc_times.delete();
    for (int i = 0; i < 4; i++) begin
      present(b2b[i]);
      q0.push_back(b2b[i].exp_rd);
      @(posedge clk);
      cs_high = 0;
      for (int c = 1; c <= LEN0; c++) begin
        @(negedge clk);
        if (ncs0 && ncs2) cs_high++;
        if (i == 3) cmd_valid = 1'b0;
      end
      chk($sformatf("b2b%0d_cs_high", i), cs_high, 32'd1);
    end
    @(negedge clk);
    chk("b2b_accepts", acc_times.size(), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (acc_times.size() > i)
        chk($sformatf("b2b_spacing%0d", i), 32'(acc_times[i] - acc_times[i-1]), 32'(LEN0 * 10));
    end
    repeat (2) @(negedge clk);

    // Reset asserted in the second strobe cycle of a write.
    present('{wr: 1'b1, cs2: 1'b1, addr: 23'h0ABCDE, wdata: 8'h55, pdv: 8'h00, exp_rd: 8'h00});
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("rstmid_in_strobe", {30'd0, nwr, ncs2}, 32'd0);
    @(posedge clk);
    #2 nreset = 1'b1;
    #1;
    chk("rstmid_async_ctl", {28'd0, ncs0, ncs2, nrd, nwr}, 32'hF);
    chk("rstmid_pd_release", {31'd0, dut0.pd_oe_r}, 32'd0);
    chk("rstmid_ready", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_idle_c%0d", c), {26'd0, ncs0, ncs2, nrd, nwr, rsp_valid, cmd_ready}, 32'b111101);
    end

    // Command pulsed while in HOLD must be ignored.
    present(busy_v);
    q0.push_back(busy_v.exp_rd);
    @(posedge clk);
    for (int c = 1; c <= LEN0; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == S0 + ST0 + 1) begin
        chk("busy_in_hold", {30'd0, nrd, ncs0}, 32'b10);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_cs2 = 1'b1; cmd_addr = 23'h000001; cmd_wdata = 8'hEE;
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("busy_no_cycle_c%0d", c), {26'd0, ncs0, ncs2, nrd, nwr, rsp_valid, cmd_ready}, 32'b111101);
    end

    // Parameter sweep instance: SETUP=1, STROBE=15, HOLD=1.
    cmd_valid1 = 1'b1; cmd_write1 = 1'b0; cmd_cs21 = 1'b1; cmd_addr1 = 23'h2AAAAA; tb_pd1 = 8'h11;
    q1.push_back(8'h22);
    @(posedge clk);
    str_cnt = 0; cs_cnt = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      cmd_valid1 = 1'b0;
      if (!nrd1) str_cnt++;
      if (!ncs21) cs_cnt++;
      if (c == 1) chk("sweep_setup_strobe_high", {31'd0, nrd1}, 32'd1);
      if (c == 2) chk("sweep_strobe_falls", {31'd0, nrd1}, 32'd0);
      if (c == 16) tb_pd1 = 8'h22;
      if (c == 17) chk("sweep_no_early_rsp", {31'd0, rsp_valid1}, 32'd0);
      if (c == 18) chk("sweep_turn", {29'd0, rsp_valid1, cmd_ready1, ncs21}, 32'b111);
    end
    chk("sweep_strobe_width", str_cnt, 32'd15);
    chk("sweep_cs_width", cs_cnt, 32'd17);
    repeat (3) @(negedge clk);

    chk("queues_drained", q0.size() + q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
